// File: rtl/disp_scheduler_pkg.sv
// Shared definitions for the display scheduling blocks: FSM state
// encodings, select-width derivation and the blank display value.
package disp_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AUTO   = 2'd1,
    MANUAL = 2'd2,
    HOLD   = 2'd3
  } disp_state_t;

  localparam logic [7:0] DISP_BLANK = 8'h00;

  // Width of a source index; never below 1 so a 2-source build still has a bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: returns the first valid index after
// cur, wrapping modulo NUM_SRC. When cur is the only valid index, or when
// nothing is valid, cur itself is returned. any_valid flags a non-empty set.
module disp_rr_pick
  import disp_scheduler_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SEL_W   = sel_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [SEL_W-1:0]   cur,
  output logic [SEL_W-1:0]   next_idx,
  output logic               any_valid
);

  int unsigned best_d;
  int unsigned d;

  // Pick the valid index at the smallest forward distance from cur (cur itself counts last).
  always_comb begin
    best_d    = NUM_SRC + 1;
    d         = 0;
    next_idx  = cur;
    any_valid = |valid;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      d = (j + NUM_SRC - 32'(cur)) % NUM_SRC;
      if (d == 0) d = NUM_SRC;
      if (valid[j] && (d < best_d)) begin
        best_d   = d;
        next_idx = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/disp_scheduler.sv
// Time-shares one two-digit hex display between NUM_SRC byte sources.
// Round-robin with a dwell timer, manual selection, freeze and turbo dwell.
// Optional macro DISP_SNAPSHOT_EN: data_out latches the selected value on
// source switches (and on leaving IDLE) instead of tracking it live.
module disp_scheduler
  import disp_scheduler_pkg::*;
#(
  parameter  int NUM_SRC        = 4,
  parameter  int DWELL_CYCLES   = 50000000,
  parameter  int TURBO_DIV_LOG2 = 4,
  localparam int SEL_W          = sel_width(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_SRC*8-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic                 manual_en,
  input  logic [SEL_W-1:0]     manual_sel,
  input  logic                 hold,
  input  logic                 turbo_mode,
  output logic [7:0]           data_out,
  output logic [SEL_W-1:0]     sel_out,
  output logic                 turbo_out,
  output logic                 switch_pulse
);

  localparam int CNT_W       = $clog2(DWELL_CYCLES);
  localparam int TURBO_SHIFT = DWELL_CYCLES >> TURBO_DIV_LOG2;
  localparam int TURBO_DWELL = (TURBO_SHIFT < 1) ? 1 : TURBO_SHIFT;
  localparam logic [CNT_W-1:0] NORM_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURBO_LAST = CNT_W'(TURBO_DWELL - 1);

  disp_state_t      state_q, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [SEL_W-1:0] sel_prev;
  logic [SEL_W-1:0] pick_cur;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] man_sel;
  logic             any_valid;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] dwell_last;
  logic [7:0]       data_n;
  logic [7:0]       src_arr [NUM_SRC];

  // Unpack the source bus into per-source bytes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_arr[i] = src_data[8*i +: 8];
    end
  end

  // Picker input: from IDLE search "at or after" sel_out by starting one
  // position earlier; otherwise search strictly after sel_out.
  always_comb begin
    sel_prev = (sel_out == '0) ? SEL_W'(NUM_SRC - 1) : sel_out - 1'b1;
    pick_cur = (state_q == IDLE) ? sel_prev : sel_out;
  end

  disp_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .valid     (src_valid),
    .cur       (pick_cur),
    .next_idx  (pick_idx),
    .any_valid (any_valid)
  );

  // Manual index clamp and the active dwell limit.
  always_comb begin
    man_sel    = (32'(manual_sel) >= NUM_SRC) ? SEL_W'(NUM_SRC - 1) : manual_sel;
    dwell_last = turbo_mode ? TURBO_LAST : NORM_LAST;
  end

  // Next state, selection and dwell count in priority order.
  always_comb begin
    sel_n = sel_out;
    cnt_n = cnt_q;
    if (manual_en)                      state_n = MANUAL;
    else if (hold && (state_q != IDLE)) state_n = HOLD;
    else if (!any_valid)                state_n = IDLE;
    else                                state_n = AUTO;

    case (state_n)
      MANUAL: begin
        sel_n = man_sel;
        cnt_n = '0;
      end
      HOLD: ;
      IDLE: cnt_n = '0;
      AUTO: begin
        if (state_q == IDLE) begin
          sel_n = pick_idx;
          cnt_n = '0;
        end else if (state_q == MANUAL) begin
          cnt_n = '0;
        end else if (!src_valid[sel_out] || (cnt_q >= dwell_last)) begin
          sel_n = pick_idx;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Display value for the next cycle.
  always_comb begin
`ifdef DISP_SNAPSHOT_EN
    data_n = data_out;
    if (state_n == IDLE) begin
      data_n = DISP_BLANK;
    end else if ((sel_n != sel_out) || (state_q == IDLE)) begin
      data_n = src_arr[sel_n];
    end else if (((state_n == HOLD) || (state_n == MANUAL)) && src_valid[sel_n] &&
                 (src_arr[sel_n] != data_out)) begin
      data_n = src_arr[sel_n];
    end
`else
    data_n = (state_n == IDLE) ? DISP_BLANK : src_arr[sel_n];
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_out      <= '0;
      data_out     <= DISP_BLANK;
      turbo_out    <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      sel_out      <= sel_n;
      data_out     <= data_n;
      turbo_out    <= turbo_mode;
      switch_pulse <= (sel_n != sel_out);
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler: round-robin dwell, turbo, manual,
// hold, valid drop, IDLE re-entry and asynchronous reset. A second
// instance with NUM_SRC=5 covers the manual_sel clamp.
module tb_disp_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] src_data;
  logic [3:0]  src_valid;
  logic        manual_en;
  logic [1:0]  manual_sel;
  logic        hold;
  logic        turbo_mode;
  logic [7:0]  data_out;
  logic [1:0]  sel_out;
  logic        turbo_out;
  logic        switch_pulse;

  logic [39:0] src_data5;
  logic [4:0]  src_valid5;
  logic        manual_en5;
  logic [2:0]  manual_sel5;
  logic [7:0]  data_out5;
  logic [2:0]  sel_out5;
  logic        turbo_out5;
  logic        switch_pulse5;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int pulse_base;

  always #5 clk = ~clk;

  disp_scheduler #(
    .NUM_SRC        (4),
    .DWELL_CYCLES   (16),
    .TURBO_DIV_LOG2 (2)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .manual_en    (manual_en),
    .manual_sel   (manual_sel),
    .hold         (hold),
    .turbo_mode   (turbo_mode),
    .data_out     (data_out),
    .sel_out      (sel_out),
    .turbo_out    (turbo_out),
    .switch_pulse (switch_pulse)
  );

  disp_scheduler #(
    .NUM_SRC        (5),
    .DWELL_CYCLES   (16),
    .TURBO_DIV_LOG2 (2)
  ) u_dut5 (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_data     (src_data5),
    .src_valid    (src_valid5),
    .manual_en    (manual_en5),
    .manual_sel   (manual_sel5),
    .hold         (1'b0),
    .turbo_mode   (1'b0),
    .data_out     (data_out5),
    .sel_out      (sel_out5),
    .turbo_out    (turbo_out5),
    .switch_pulse (switch_pulse5)
  );

  // Count switch pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (switch_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    src_data    = '0;
    src_valid   = '0;
    manual_en   = 1'b0;
    manual_sel  = '0;
    hold        = 1'b0;
    turbo_mode  = 1'b0;
    src_data5   = '0;
    src_valid5  = '0;
    manual_en5  = 1'b0;
    manual_sel5 = '0;

    step(2);
    check("rst_data", data_out, 8'h00);
    check("rst_sel", sel_out, 0);
    check("rst_pulse", switch_pulse, 0);
    check("rst_turbo", turbo_out, 0);
    reset_n = 1'b1;
    step(3);
    check("idle_data", data_out, 8'h00);
    check("idle_sel", sel_out, 0);
    check("idle_pulse", switch_pulse, 0);

    // Round-robin over sources 0,1,3 with a 16-cycle dwell.
    src_data   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    src_valid  = 4'b1011;
    pulse_base = pulse_cnt;
    step(1);
    check("start_sel", sel_out, 0);
    check("start_data", data_out, 8'hAA);
    check("start_pulse", switch_pulse, 0);
    step(15);
    check("dwell0_end_sel", sel_out, 0);
    step(1);
    check("rr1_sel", sel_out, 1);
    check("rr1_data", data_out, 8'hBB);
    check("rr1_pulse", switch_pulse, 1);
    step(15);
    check("dwell1_end_sel", sel_out, 1);
    step(1);
    check("rr3_sel", sel_out, 3);
    check("rr3_data", data_out, 8'hDD);
    step(15);
    check("dwell3_end_sel", sel_out, 3);
    step(1);
    check("rr0_sel", sel_out, 0);
    check("rr0_data", data_out, 8'hAA);
    step(1);
    check("rr_pulse_count", pulse_cnt - pulse_base, 3);

    // Turbo: dwell shrinks to 4; counter is at 1 when turbo rises.
    turbo_mode = 1'b1;
    check("turbo_lag0", turbo_out, 0);
    step(1);
    check("turbo_lag1", turbo_out, 1);
    step(1);
    check("turbo_pre_sel", sel_out, 0);
    step(1);
    check("turbo_adv1_sel", sel_out, 1);
    check("turbo_adv1_data", data_out, 8'hBB);
    step(3);
    check("turbo_dwell_sel", sel_out, 1);
    step(1);
    check("turbo_adv3_sel", sel_out, 3);
    turbo_mode = 1'b0;
    check("turbo_off_lag0", turbo_out, 1);
    step(1);
    check("turbo_off_lag1", turbo_out, 0);
    step(7);
    check("normal_no_adv_sel", sel_out, 3);
    // Count is 8, above the turbo limit: advance on the next edge.
    turbo_mode = 1'b1;
    step(1);
    check("turbo_exceed_sel", sel_out, 0);
    check("turbo_exceed_pulse", switch_pulse, 1);
    turbo_mode = 1'b0;

    // Manual selection mid-dwell.
    step(5);
    manual_en  = 1'b1;
    manual_sel = 2'd2;
    step(1);
    check("manual_sel", sel_out, 2);
    check("manual_data", data_out, 8'hCC);
    check("manual_pulse", switch_pulse, 1);
    manual_sel = 2'(7);   // 7 truncates to 3 on a 2-bit port
    step(1);
    check("manual_max_sel", sel_out, 3);
    check("manual_max_data", data_out, 8'hDD);
    manual_en = 1'b0;
    step(1);
    check("manual_exit_sel", sel_out, 3);
    check("manual_exit_pulse", switch_pulse, 0);
    step(15);
    check("manual_exit_dwell_sel", sel_out, 3);
    step(1);
    check("manual_exit_adv_sel", sel_out, 0);

    // Hold for 40 cycles mid-dwell; data still tracks live value.
    step(5);
    hold       = 1'b1;
    pulse_base = pulse_cnt;
    step(5);
    check("hold_sel_a", sel_out, 0);
    src_data[7:0] = 8'h5A;
    step(1);
    check("hold_live_data", data_out, 8'h5A);
    src_data[7:0] = 8'hAA;
    step(34);
    check("hold_sel_b", sel_out, 0);
    check("hold_no_pulse", pulse_cnt - pulse_base, 0);
    hold = 1'b0;
    step(10);
    check("hold_resume_sel", sel_out, 0);
    step(1);
    check("hold_resume_adv", sel_out, 1);

    // Dwell expiry coinciding with hold rising: no advance.
    step(15);
    hold = 1'b1;
    step(1);
    check("expiry_hold_sel", sel_out, 1);
    check("expiry_hold_pulse", switch_pulse, 0);
    hold = 1'b0;
    step(1);
    check("expiry_release_sel", sel_out, 3);

    // Current source drops valid mid-dwell.
    step(3);
    src_valid = 4'b0011;
    step(1);
    check("drop_sel", sel_out, 0);
    check("drop_data", data_out, 8'hAA);
    check("drop_pulse", switch_pulse, 1);

    // IDLE then re-entry picks at-or-after sel_out (0, not 2).
    src_valid = 4'b0000;
    step(1);
    check("idle2_data", data_out, 8'h00);
    check("idle2_sel", sel_out, 0);
    src_valid = 4'b0101;
    step(1);
    check("reenter_sel", sel_out, 0);
    check("reenter_data", data_out, 8'hAA);
    check("reenter_pulse", switch_pulse, 0);

    // Asynchronous reset between edges.
    src_valid  = 4'b1111;
    turbo_mode = 1'b1;
    manual_en  = 1'b1;
    manual_sel = 2'd2;
    step(1);
    check("pre_areset_sel", sel_out, 2);
    check("pre_areset_turbo", turbo_out, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_data", data_out, 8'h00);
    check("areset_sel", sel_out, 0);
    check("areset_turbo", turbo_out, 0);
    check("areset_pulse", switch_pulse, 0);
    src_valid  = '0;
    turbo_mode = 1'b0;
    manual_en  = 1'b0;
    manual_sel = '0;
    step(2);
    reset_n = 1'b1;

    // Manual clamp on a 5-source instance.
    src_data5   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    manual_en5  = 1'b1;
    manual_sel5 = 3'd7;
    step(1);
    check("clamp7_sel", sel_out5, 4);
    check("clamp7_data", data_out5, 8'h55);
    manual_sel5 = 3'd5;
    step(1);
    check("clamp5_sel", sel_out5, 4);
    check("clamp5_pulse", switch_pulse5, 0);
    manual_sel5 = 3'd1;
    step(1);
    check("manual5_sel", sel_out5, 1);
    check("manual5_data", data_out5, 8'h22);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
